// File: rtl/fifo.sv
// rtl/fifo.sv - single-clock first-word-fall-through FIFO with full/empty status
// Optional sticky overflow/underflow flags are enabled by defining FIFO_ERR_EN.
module fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] out_data,
  output logic             full,
  output logic             empty
`ifdef FIFO_ERR_EN
  ,
  output logic             overflow,
  output logic             underflow
`endif
);

  logic [WIDTH-1:0] fifo_mem [DEPTH];
  logic [AW:0]      fifo_head;
  logic [AW:0]      fifo_tail;
  logic             push_ok;
  logic             pop_ok;

  // Extra wrap bit distinguishes full from empty when the indices match.
  assign empty = (fifo_head == fifo_tail);
  assign full  = (fifo_head[AW-1:0] == fifo_tail[AW-1:0]) &&
                 (fifo_head[AW] != fifo_tail[AW]);

  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign out_data = fifo_mem[fifo_head[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_head <= '0;
      fifo_tail <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        fifo_mem[fifo_tail[AW-1:0]] <= in_data;
        fifo_tail <= fifo_tail + 1'b1;
      end
      if (pop_ok) begin
        fifo_head <= fifo_head + 1'b1;
      end
    end
  end

`ifdef FIFO_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push && full) begin
        overflow <= 1'b1;
      end
      if (pop && empty) begin
        underflow <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo.sv
// tb/tb_fifo.sv - randomized scoreboard bench for fifo against a queue model
// Sticky error flags are checked too when FIFO_ERR_EN is defined.
module tb_fifo;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] out_data;
  logic             full;
  logic             empty;
`ifdef FIFO_ERR_EN
  logic             overflow;
  logic             underflow;
  bit               exp_ovf;
  bit               exp_unf;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int exp_head = 0;
  int exp_tail = 0;
  logic [WIDTH-1:0] model [$];
  logic [WIDTH-1:0] exp_q [$];
  logic [WIDTH-1:0] vals  [5];

  fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .in_data  (in_data),
    .out_data (out_data),
`ifdef FIFO_ERR_EN
    .overflow (overflow),
    .underflow(underflow),
`endif
    .full     (full),
    .empty    (empty)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every accepted pop must present the oldest unread word.
  always @(negedge clk) begin
    if (rst === 1'b0 && pop === 1'b1 && empty === 1'b0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL pop_data: got unexpected pop of %0h expected no pop", out_data);
      end else begin
        check("pop_data", out_data, exp_q.pop_front());
      end
    end
  end

  task automatic check_status();
    check("empty", empty, model.size() == 0);
    check("full", full, model.size() == DEPTH);
    check("head_ptr", dut.fifo_head, exp_head);
    check("tail_ptr", dut.fifo_tail, exp_tail);
    if (model.size() > 0) check("head_data", out_data, model[0]);
`ifdef FIFO_ERR_EN
    check("overflow", overflow, exp_ovf);
    check("underflow", underflow, exp_unf);
`endif
  endtask

  // Called at posedge+1; applies one cycle of stimulus and advances the model.
  task automatic step(bit p_push, bit p_pop, logic [WIDTH-1:0] d);
    int sz;
    check_status();
    push    = p_push;
    pop     = p_pop;
    in_data = d;
    sz = model.size();
    if (p_pop && sz > 0) begin
      exp_q.push_back(model.pop_front());
      exp_head = (exp_head + 1) % (2 * DEPTH);
    end
    if (p_push && sz < DEPTH) begin
      model.push_back(d);
      exp_tail = (exp_tail + 1) % (2 * DEPTH);
    end
`ifdef FIFO_ERR_EN
    if (p_push && sz == DEPTH) exp_ovf = 1'b1;
    if (p_pop && sz == 0) exp_unf = 1'b1;
`endif
    @(posedge clk);
    #1;
    push = 1'b0;
    pop  = 1'b0;
  endtask

  task automatic apply_reset();
    push = 1'b0;
    pop  = 1'b0;
    rst  = 1'b1;
    #1;
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_out", out_data, 32'h0000_0000);
    check("rst_head", dut.fifo_head, 0);
    check("rst_tail", dut.fifo_tail, 0);
    for (int i = 0; i < DEPTH; i++) check("rst_mem", dut.fifo_mem[i], 0);
    model.delete();
    exp_q.delete();
    exp_head = 0;
    exp_tail = 0;
`ifdef FIFO_ERR_EN
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
`endif
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    push = 1'b0;
    pop = 1'b0;
    in_data = '0;
    @(posedge clk);
    #1;
    apply_reset();

    // Fill: the fifth push must be dropped.
    vals[0] = 32'hA0A0_0001; vals[1] = 32'hB0B0_0002; vals[2] = 32'hC0C0_0003;
    vals[3] = 32'hD0D0_0004; vals[4] = 32'hE0E0_0005;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, vals[i]);
    check("fill_full", full, 1'b1);
    check("fill_tail", dut.fifo_tail, 4);
    for (int i = 0; i < DEPTH; i++) check("fill_mem", dut.fifo_mem[i], vals[i]);

    // Partial drain from full.
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b1, '0);
    check("drain_out", out_data, vals[2]);
    check("drain_head", dut.fifo_head, 2);

    // Wrap-around at occupancy 2/3.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, $urandom);
      step(1'b0, 1'b1, '0);
    end

    // Drain to empty, then one rejected pop.
    while (model.size() > 0) step(1'b0, 1'b1, '0);
    step(1'b0, 1'b1, '0);
    check_status();

    // Simultaneous push+pop at occupancy 2, then while empty.
    step(1'b1, 1'b0, $urandom);
    step(1'b1, 1'b0, $urandom);
    step(1'b1, 1'b1, $urandom);
    check("simul_occ", (dut.fifo_tail - dut.fifo_head) & 3'h7, 2);
    while (model.size() > 0) step(1'b0, 1'b1, '0);
    step(1'b1, 1'b1, 32'h5A5A_A5A5);
    check("empty_pp_out", out_data, 32'h5A5A_A5A5);

    // Random traffic.
    for (int i = 0; i < 200; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
    end

    // Mid-stream asynchronous reset.
    while (model.size() < 3) step(1'b1, 1'b0, $urandom);
    apply_reset();
    step(1'b1, 1'b0, 32'h1234_5678);
    step(1'b0, 1'b1, '0);
    check_status();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo.md
Name: fifo

Overview:
- Synchronous single-clock first-in-first-out buffer with push/pop handshake and full/empty status.
- Sits between a producer and a consumer in the same clock domain.
- Output is first-word-fall-through: the head entry is always visible on out_data without a read latency.
- Default configuration is 32-bit words, 4 entries deep.

Parameters:
- WIDTH, 32, data word width in bits; in_data/out_data are WIDTH-1:0.
- DEPTH, 4, number of storage entries; must be a power of two, >= 2.
- AW, log2(DEPTH), address width; the head/tail pointers are AW+1 bits wide (extra wrap bit).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high; clears all state immediately.
- push  input  1  write request; sampled at the rising edge of clk.
- pop  input  1  read/advance request; sampled at the rising edge of clk.
- in_data  input  WIDTH  word written when a push is accepted.
- out_data  output  WIDTH  current head entry (combinational from storage).
- full  output  1  high when DEPTH entries are held.
- empty  output  1  high when 0 entries are held.
- overflow  output  1  sticky flag; present only with FIFO_ERR_EN.
- underflow  output  1  sticky flag; present only with FIFO_ERR_EN.

Behaviour:
- Storage: fifo_mem[0..DEPTH-1]; head pointer fifo_head and tail pointer fifo_tail, each AW+1 bits.
- Reset (rst=1, asynchronous):
  - fifo_head = fifo_tail = 0.
  - All fifo_mem entries = 0.
  - empty = 1, full = 0, out_data = 0.
  - Error flags = 0.
  - Holds while rst is high; a reset mid-operation discards all contents.
- Status decode (combinational from the pointers):
  - empty = (head == tail).
  - full = low AW bits equal AND wrap bits differ.
- Push is accepted iff push=1 and full=0 at the edge:
  - fifo_mem[tail[AW-1:0]] <= in_data; tail <= tail+1.
- Pop is accepted iff pop=1 and empty=0 at the edge:
  - head <= head+1.
  - Popped entry contents are left unchanged in memory.
- Push while full: ignored; memory and pointers unchanged.
- Pop while empty: ignored; pointers unchanged.
- Simultaneous push and pop: each is evaluated independently against the pre-edge full/empty.
  - Neither full nor empty: both take effect, and occupancy is unchanged.
  - Full: only the pop takes effect.
  - Empty: only the push takes effect.
- out_data = fifo_mem[head[AW-1:0]] at all times, i.e. zero cycles from a push to visibility once the FIFO is non-empty.
- When empty, out_data shows the stale or reset entry at head; consumers must qualify it with empty.
- Pointers wrap modulo 2*DEPTH naturally; storage index wraps modulo DEPTH.
- Occupancy is always in the range 0..DEPTH.
- Latency: full/empty update in the same cycle as the pointer change, after the edge.

Optional Feature:
- Macro FIFO_ERR_EN.
- When defined:
  - Adds the overflow and underflow output ports.
  - overflow is set on an edge where push=1 and full=1.
  - underflow is set on an edge where pop=1 and empty=1.
  - Both flags are sticky until rst.
  - Push/pop behaviour is otherwise identical.
- When undefined: the ports and their logic are absent; rejected requests are silently dropped.

Test Plan:
- Reset: assert rst with push/pop idle.
  - Expect empty=1, full=0, head=tail=0, all mem=0.
  - Expect out_data=0x00000000.
- Fill:
  - Five consecutive pushes of values A..E.
  - After the 4th push: full=1 and mem[0..3]=A,B,C,D.
  - The 5th push is dropped: tail unchanged, E not stored, overflow=1 if FIFO_ERR_EN.
- Drain partially:
  - Two pops from full.
  - out_data goes A -> B -> C; full=0, empty=0, head=2.
- Wrap-around: 16 iterations of a push of a random word followed by a pop.
  - Occupancy stays 2/3, and pointers wrap past index 3 repeatedly.
  - Every popped word equals the word pushed 2 entries earlier, in FIFO order.
- Empty and underflow:
  - Pop until empty=1, then one more pop.
  - head is unchanged and underflow=1 if FIFO_ERR_EN.
- Simultaneous and reset corner cases:
  - Push+pop in the same cycle at occupancy 2: occupancy stays 2.
  - Push+pop while empty: only the push takes effect.
  - Assert rst mid-stream: immediately empty=1, full=0.
